// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Exception codes are also consumed by CP0.
package dm_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badva;
  } dm_resp_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    unique case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_lane_extract.sv
// Lane decode: byte enables and extended load data
// for a given byte offset, size and signedness.
module dm_lane_extract
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [3:0]  be,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be     = 4'b0000;
    result = 32'h0;
    b      = word[{off, 3'b000} +: 8];
    h      = off[1] ? word[31:16] : word[15:0];
    unique case (1'b1)
      (size == SZ_BYTE): begin
        be     = 4'b0001 << off;
        result = {{24{sgn & b[7]}}, b};
      end
      (size == SZ_HALF): begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        result = {{16{sgn & h[15]}}, h};
      end
      (size == SZ_WORD): begin
        be     = 4'b1111;
        result = word;
      end
      default: begin
        be     = 4'b0000;
        result = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator for the 4 KB data memory:
// checks, drives the port, returns a registered response.
module dm_access_ctrl #(
  parameter int DM_WORDS = 1024,
  parameter logic [4:0] EXC_ADEL =
    dm_access_ctrl_pkg::EXC_ADEL,
  parameter logic [4:0] EXC_ADES =
    dm_access_ctrl_pkg::EXC_ADES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic [31:0] resp_badva,
  output logic [9:0]  dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  import dm_access_ctrl_pkg::*;

  localparam logic [32:0] LIMIT =
    33'(4 * DM_WORDS);

  state_t   state, state_nx;
  dm_req_t  rq;
  dm_resp_t rs;

  logic        in_acc;
  logic        bad;
  logic        legal;
  logic [3:0]  be;
  logic [31:0] ext;

  assign in_acc = (state == ST_ACCESS);
  assign bad    = misaligned(rq.size, rq.addr[1:0])
               || ({1'b0, rq.addr} >= LIMIT);
  assign legal  = in_acc && !bad;

  dm_lane_extract u_lane (
    .word   (dm_dout),
    .off    (rq.addr[1:0]),
    .size   (rq.size),
    .sgn    (rq.sgn),
    .be     (be),
    .result (ext)
  );

  // Port outputs are pure decode so reset kills dm_we at once
  assign dm_we   = legal && rq.we;
  assign dm_be   = legal ? be : 4'b0000;
  assign dm_addr = legal ? rq.addr[11:2] : 10'h0;
  assign dm_din  = dm_we ? rq.wdata : 32'h0;

  assign req_ready    = (state == ST_IDLE);
  assign resp_valid   = (state == ST_RESP);
  assign resp_rdata   = rs.rdata;
  assign resp_exc     = rs.exc;
  assign resp_exccode = rs.code;
  assign resp_badva   = rs.badva;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (req_valid) state_nx = ST_ACCESS;
      ST_ACCESS:
        state_nx = ST_RESP;
      ST_RESP:
        if (resp_ready) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rq    <= '0;
      rs    <= '0;
    end else begin
      state <= state_nx;
      if (req_ready && req_valid) begin
        rq.we    <= req_we;
        rq.size  <= req_size;
        rq.sgn   <= req_signed;
        rq.addr  <= req_addr;
        rq.wdata <= req_wdata;
      end
      if (in_acc) begin
        rs.rdata <= (!bad && !rq.we) ? ext : 32'h0;
        rs.exc   <= bad;
        rs.code  <= !bad ? 5'd0
                  : rq.we ? EXC_ADES : EXC_ADEL;
        rs.badva <= bad ? rq.addr : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench with memory model and response
// scoreboard for dm_access_ctrl.
module tb_dm_access_ctrl;
  import dm_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exccode;
  logic [31:0] resp_badva;
  logic [9:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badva;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [1024];
  int          n_pass = 0;
  int          n_total = 0;
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exccode(resp_exccode),
    .resp_badva(resp_badva),
    .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      case (dm_be)
        4'b0001: mem[dm_addr][7:0]   <= dm_din[7:0];
        4'b0010: mem[dm_addr][15:8]  <= dm_din[7:0];
        4'b0100: mem[dm_addr][23:16] <= dm_din[7:0];
        4'b1000: mem[dm_addr][31:24] <= dm_din[7:0];
        4'b0011: mem[dm_addr][15:0]  <= dm_din[15:0];
        4'b1100: mem[dm_addr][31:16] <= dm_din[15:0];
        4'b1111: mem[dm_addr]        <= dm_din;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  task automatic do_req(
    input string       tag,
    input logic        we,
    input logic [1:0]  sz,
    input logic        sgn,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [3:0]  ebe,
    input logic [31:0] erd,
    input logic        eexc,
    input logic [4:0]  ecode,
    input int          hold
  );
    exp_t e, o;
    logic [31:0] held;
    e.rdata = erd;
    e.exc   = eexc;
    e.code  = ecode;
    e.badva = eexc ? a : 32'h0;
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we;
    req_size = sz; req_signed = sgn;
    req_addr = a; req_wdata = wd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".be"}, 32'(dm_be), 32'(ebe));
    chk({tag, ".we"}, 32'(dm_we),
        32'(we && !eexc));
    if (we && !eexc)
      chk({tag, ".din"}, dm_din, wd);
    @(posedge clk); #1;
    chk({tag, ".rv"}, 32'(resp_valid), 32'd1);
    held = resp_rdata;
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b1;
      req_size = SZ_WORD; req_addr = 32'h10;
      req_wdata = 32'h0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, ".hrv"}, 32'(resp_valid), 32'd1);
        chk({tag, ".hrdy"}, 32'(req_ready), 32'd0);
        chk({tag, ".hrd"}, resp_rdata, held);
        chk({tag, ".hwe"}, 32'(dm_we), 32'd0);
      end
      req_valid = 1'b0;
    end
    if (exp_q.size() == 0) begin
      chk({tag, ".qempty"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      chk({tag, ".rdata"}, resp_rdata, o.rdata);
      chk({tag, ".exc"}, 32'(resp_exc), 32'(o.exc));
      chk({tag, ".code"}, 32'(resp_exccode),
          32'(o.code));
      chk({tag, ".badva"}, resp_badva, o.badva);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".rv0"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.rdy", 32'(req_ready), 32'd1);
    chk("rst.rv", 32'(resp_valid), 32'd0);
    chk("rst.rd", resp_rdata, 32'h0);
    chk("rst.exc", 32'(resp_exc), 32'd0);
    chk("rst.code", 32'(resp_exccode), 32'd0);
    chk("rst.badva", resp_badva, 32'h0);
    chk("rst.we", 32'(dm_we), 32'd0);
    chk("rst.be", 32'(dm_be), 32'd0);
    chk("rst.addr", 32'(dm_addr), 32'd0);
    chk("rst.din", dm_din, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req("sw10", 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF,
           4'b1111, 32'h0, 0, 5'd0, 0);
    do_req("lw10", 0, SZ_WORD, 0, 32'h10, 32'h0,
           4'b1111, 32'hDEADBEEF, 0, 5'd0, 0);
    do_req("sb13", 1, SZ_BYTE, 0, 32'h13, 32'h85,
           4'b1000, 32'h0, 0, 5'd0, 0);
    do_req("lb13", 0, SZ_BYTE, 1, 32'h13, 32'h0,
           4'b1000, 32'hFFFFFF85, 0, 5'd0, 0);
    do_req("lbu13", 0, SZ_BYTE, 0, 32'h13, 32'h0,
           4'b1000, 32'h00000085, 0, 5'd0, 0);
    do_req("lbu10", 0, SZ_BYTE, 0, 32'h10, 32'h0,
           4'b0001, 32'h000000EF, 0, 5'd0, 0);
    do_req("sw14", 1, SZ_WORD, 0, 32'h14, 32'h12345678,
           4'b1111, 32'h0, 0, 5'd0, 0);
    do_req("sh16", 1, SZ_HALF, 0, 32'h16, 32'h8001,
           4'b1100, 32'h0, 0, 5'd0, 0);
    do_req("lh16", 0, SZ_HALF, 1, 32'h16, 32'h0,
           4'b1100, 32'hFFFF8001, 0, 5'd0, 0);
    do_req("lhu14", 0, SZ_HALF, 0, 32'h14, 32'h0,
           4'b0011, 32'h00005678, 0, 5'd0, 0);
    do_req("lw12", 0, SZ_WORD, 0, 32'h12, 32'h0,
           4'b0000, 32'h0, 1, EXC_ADEL, 0);
    do_req("sh11", 1, SZ_HALF, 0, 32'h11, 32'hFFFF,
           4'b0000, 32'h0, 1, EXC_ADES, 0);
    do_req("lw10b", 0, SZ_WORD, 0, 32'h10, 32'h0,
           4'b1111, 32'h85ADBEEF, 0, 5'd0, 0);
    do_req("sw1000", 1, SZ_WORD, 0, 32'h1000, 32'h1,
           4'b0000, 32'h0, 1, EXC_ADES, 0);
    do_req("lsz3", 0, SZ_BAD, 0, 32'h10, 32'h0,
           4'b0000, 32'h0, 1, EXC_ADEL, 0);
    do_req("hold", 0, SZ_WORD, 0, 32'h14, 32'h0,
           4'b1111, 32'h80015678, 0, 5'd0, 5);
    do_req("lw10c", 0, SZ_WORD, 0, 32'h10, 32'h0,
           4'b1111, 32'h85ADBEEF, 0, 5'd0, 0);

    req_valid = 1'b1; req_we = 1'b1;
    req_size = SZ_WORD; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("arst.we1", 32'(dm_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.we0", 32'(dm_we), 32'd0);
    chk("arst.be0", 32'(dm_be), 32'd0);
    chk("arst.rv", 32'(resp_valid), 32'd0);
    chk("arst.rdy", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_req("lw20", 0, SZ_WORD, 0, 32'h20, 32'h0,
           4'b1111, 32'h0, 0, 5'd0, 0);
    chk("wr_cnt", 32'(wr_cnt), 32'd4);
    chk("q_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
